// File: rtl/branch_resolve_unit.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : branch_resolve_unit
// Description : In-order queue of fetch-time BTB predictions, checked against
//               execute-stage outcomes; emits flush/redirect and BTB updates.
//               Optional counters are built when BRU_STATS_EN is defined.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    input  logic        pred_hit,
    input  logic [31:0] pred_target,
    output logic        pred_ready,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        res_ready,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        btb_valid,
    output logic [31:0] btb_pc,
    output logic [31:0] btb_target,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispredict
);

    localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);

    logic [31:0]      r_q_pc  [DEPTH];
    logic             r_q_hit [DEPTH];
    logic [31:0]      r_q_tgt [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic             r_flush;
    logic [31:0]      r_redirect_pc;
    logic             r_btb_valid;
    logic [31:0]      r_btb_pc;
    logic [31:0]      r_btb_target;

    logic             w_push;
    logic             w_push_eff;
    logic             w_pop;
    logic [31:0]      w_head_pc;
    logic             w_head_hit;
    logic [31:0]      w_head_tgt;
    logic             w_mis_taken;
    logic             w_mis_not_taken;
    logic             w_mis;

    // Ready flags look only at registered state, never at same-cycle pops.
    assign pred_ready = (r_count != C_FULL) & ~r_flush;
    assign res_ready  = (r_count != '0);

    assign w_push     = pred_valid & pred_ready;
    assign w_pop      = res_valid & res_ready;
    assign w_head_pc  = r_q_pc[r_rd_ptr];
    assign w_head_hit = r_q_hit[r_rd_ptr];
    assign w_head_tgt = r_q_tgt[r_rd_ptr];

    assign w_mis_taken     = w_pop & res_taken & (~w_head_hit | (w_head_tgt != res_target));
    assign w_mis_not_taken = w_pop & ~res_taken & w_head_hit;
    assign w_mis           = w_mis_taken | w_mis_not_taken;
    // A push in a mispredict cycle is wrong-path and is discarded.
    assign w_push_eff      = w_push & ~w_mis;

    always_ff @(posedge clk) begin
        if (w_push_eff) begin
            r_q_pc[r_wr_ptr]  <= pred_pc;
            r_q_hit[r_wr_ptr] <= pred_hit;
            r_q_tgt[r_wr_ptr] <= pred_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_mis) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push_eff) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push_eff, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_btb_valid   <= 1'b0;
            r_btb_pc      <= '0;
            r_btb_target  <= '0;
        end else begin
            r_flush       <= w_mis;
            r_redirect_pc <= w_mis_taken     ? res_target :
                             w_mis_not_taken ? (w_head_pc + 32'd4) : 32'd0;
            r_btb_valid   <= w_mis_taken;
            r_btb_pc      <= w_mis_taken ? w_head_pc  : 32'd0;
            r_btb_target  <= w_mis_taken ? res_target : 32'd0;
        end
    end

    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;
    assign btb_valid   = r_btb_valid;
    assign btb_pc      = r_btb_pc;
    assign btb_target  = r_btb_target;

`ifdef BRU_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispredict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_resolved   <= '0;
            r_stat_mispredict <= '0;
        end else begin
            if (w_pop) begin
                r_stat_resolved <= r_stat_resolved + 32'd1;
            end
            if (w_mis) begin
                r_stat_mispredict <= r_stat_mispredict + 32'd1;
            end
        end
    end

    assign stat_resolved   = r_stat_resolved;
    assign stat_mispredict = r_stat_mispredict;
`else
    assign stat_resolved   = 32'd0;
    assign stat_mispredict = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : tb_branch_resolve_unit
// Description : Scoreboard bench for branch_resolve_unit with a queue-based
//               reference model; honours BRU_STATS_EN like the design.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_ready;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        btb_valid;
    logic [31:0] btb_pc;
    logic [31:0] btb_target;
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredict;

    branch_resolve_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_hit(pred_hit),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .res_ready(res_ready), .flush(flush), .redirect_pc(redirect_pc),
        .btb_valid(btb_valid), .btb_pc(btb_pc), .btb_target(btb_target),
        .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic [31:0] redir;
        logic        bv;
        logic [31:0] bpc;
        logic [31:0] btgt;
    } ev_t;

    ent_t        mq[$];
    ev_t         sb[$];
    ev_t         mon_ev;
    int          checks   = 0;
    int          failures = 0;
    bit          m_flush  = 1'b0;
    int unsigned m_res    = 0;
    int unsigned m_mis    = 0;

    // One clock of stimulus: entered and left at posedge+1.
    task automatic cycle(input logic pv, input logic [31:0] pc, input logic ph,
                         input logic [31:0] pt, input logic rv, input logic rt,
                         input logic [31:0] rtg);
        bit   er;
        bit   eq;
        bit   mis;
        ent_t e;
        ev_t  ev;
        pred_valid  = pv;
        pred_pc     = pc;
        pred_hit    = ph;
        pred_target = pt;
        res_valid   = rv;
        res_taken   = rt;
        res_target  = rtg;
        er = (mq.size() != DEPTH) && !m_flush;
        eq = (mq.size() != 0);
        checks++;
        if (pred_ready !== er) begin
            failures++;
            $display("FAIL pred_ready got=%0b exp=%0b t=%0t", pred_ready, er, $time);
        end
        checks++;
        if (res_ready !== eq) begin
            failures++;
            $display("FAIL res_ready got=%0b exp=%0b t=%0t", res_ready, eq, $time);
        end
        mis = 1'b0;
        ev  = '{32'd0, 1'b0, 32'd0, 32'd0};
        if (rv && eq) begin
            e = mq.pop_front();
            m_res++;
            // Wrong if the taken/not-taken guess differs, or the taken target differs.
            if ((rt != e.hit) || (rt && (e.tgt != rtg))) begin
                mis = 1'b1;
                m_mis++;
                ev.redir = rt ? rtg : (e.pc + 32'd4);
                ev.bv    = rt;
                ev.bpc   = rt ? e.pc : 32'd0;
                ev.btgt  = rt ? rtg : 32'd0;
                mq.delete();
            end
        end
        if (pv && er && !mis) begin
            mq.push_back('{pc, ph, pt});
        end
        m_flush = mis;
        @(posedge clk);
        #1;
        if (mis) begin
            sb.push_back(ev);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic check_stats(input string tag);
        logic [31:0] er;
        logic [31:0] em;
`ifdef BRU_STATS_EN
        er = m_res;
        em = m_mis;
`else
        er = 32'd0;
        em = 32'd0;
`endif
        checks++;
        if (stat_resolved !== er || stat_mispredict !== em) begin
            failures++;
            $display("FAIL stats_%s got=%0d/%0d exp=%0d/%0d", tag,
                     stat_resolved, stat_mispredict, er, em);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'd0 || btb_valid !== 1'b0 ||
            btb_pc !== 32'd0 || btb_target !== 32'd0 || pred_ready !== 1'b1 ||
            res_ready !== 1'b0 || stat_resolved !== 32'd0 || stat_mispredict !== 32'd0) begin
            failures++;
            $display("FAIL reset_%s flush=%0b redir=%h bv=%0b bpc=%h btgt=%h pr=%0b rr=%0b exp all zero, pr=1",
                     tag, flush, redirect_pc, btb_valid, btb_pc, btb_target, pred_ready, res_ready);
        end
    endtask

    // Monitor: each registered event is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush || btb_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_flush flush=%0b redir=%h bv=%0b exp=no event",
                             flush, redirect_pc, btb_valid);
                end else begin
                    mon_ev = sb.pop_front();
                    if (flush !== 1'b1 || redirect_pc !== mon_ev.redir || btb_valid !== mon_ev.bv ||
                        btb_pc !== mon_ev.bpc || btb_target !== mon_ev.btgt) begin
                        failures++;
                        $display("FAIL flush_event got=%0b/%h/%0b/%h/%h exp=1/%h/%0b/%h/%h",
                                 flush, redirect_pc, btb_valid, btb_pc, btb_target,
                                 mon_ev.redir, mon_ev.bv, mon_ev.bpc, mon_ev.btgt);
                    end
                end
            end else begin
                checks++;
                if (sb.size() != 0) begin
                    failures++;
                    mon_ev = sb.pop_front();
                    $display("FAIL missing_flush got=0 exp redirect=%h", mon_ev.redir);
                end else if (redirect_pc !== 32'd0 || btb_pc !== 32'd0 || btb_target !== 32'd0) begin
                    failures++;
                    $display("FAIL idle_outputs redir=%h bpc=%h btgt=%h exp=0",
                             redirect_pc, btb_pc, btb_target);
                end
            end
        end
    end

    initial begin
        logic        pv;
        logic        rv;
        logic        rt;
        logic [31:0] rtg;
        int          pct;
        rst = 1'b1;
        pred_valid = 1'b0; pred_pc = '0; pred_hit = 1'b0; pred_target = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        #1;
        check_reset_outputs("initial");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Correct hit, BTB miss, wrong target, false hit, false hit with PC wrap.
        cycle(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h200);
        idle();
        cycle(1'b1, 32'h104, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h300);
        idle();
        cycle(1'b1, 32'h108, 1'b1, 32'h400, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h500);
        idle();
        cycle(1'b1, 32'h10C, 1'b1, 32'h600, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        idle();
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        idle();
        check_stats("directed");

        // Fill, refused ninth push, mispredict drops younger entries and same-cycle push.
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(1'b1, 32'h200 + 32'(i) * 32'd4, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        end
        cycle(1'b1, 32'h400, 1'b0, 32'd0, 1'b1, 1'b1, 32'h800);
        cycle(1'b1, 32'h404, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        idle();

        // Reset while a flush pulse is being presented.
        cycle(1'b1, 32'h500, 1'b1, 32'h900, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 32'h504, 1'b0, 32'd0, 1'b1, 1'b1, 32'hA00);
        rst = 1'b1;
        #1;
        check_reset_outputs("midstream");
        sb.delete();
        mq.delete();
        m_flush = 1'b0;
        m_res = 0;
        m_mis = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Ten resolves, three of them wrong.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h600 + 32'(i) * 32'd4, 1'b1, 32'hB00, 1'b0, 1'b0, 32'd0);
            cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, (i % 3 == 1) ? 32'hC00 : 32'hB00);
        end
        idle();
        check_stats("ten");

        // Randomized traffic with alternating fill/drain bias.
        for (int i = 0; i < 800; i++) begin
            pct = ((i % 200) < 100) ? 80 : 30;
            pv  = ($urandom_range(99) < pct);
            rv  = ($urandom_range(99) < (110 - pct));
            rt  = 1'($urandom_range(1));
            rtg = 32'h1000 + 32'($urandom_range(2)) * 32'd4;
            if (mq.size() != 0 && $urandom_range(3) != 0) begin
                rt  = mq[0].hit;
                rtg = mq[0].tgt;
            end
            cycle(pv, 32'h100 + 32'($urandom_range(15)) * 32'd4, 1'($urandom_range(1)),
                  32'h1000 + 32'($urandom_range(2)) * 32'd4, rv, rt, rtg);
        end
        idle();
        idle();
        check_stats("random");
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

- Tracks every BTB prediction made at fetch in an in-order queue.
- Checks each prediction against the outcome resolved at execute.
- On a wrong prediction, pulses a pipeline flush and redirect PC.
- Drives the BTB update port (`valid_in`, `branch_PC`, `branch_target`); it sits between the IF-stage BTB lookup and the EX-stage branch unit.

## Interface
Parameters:
- DEPTH, 8, in-flight queue entries; power of 2, ≥2
- PTR_W, $clog2(DEPTH), queue pointer width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- pred_valid  in  1  fetch pushes one prediction this cycle
- pred_pc  in  32  PC of the fetched instruction
- pred_hit  in  1  BTB hit at fetch, meaning predicted taken
- pred_target  in  32  BTB target_addr at fetch
- pred_ready  out  1  push is accepted this cycle
- res_valid  in  1  execute resolves the oldest queued instruction
- res_taken  in  1  instruction is an actually-taken control transfer
- res_target  in  32  actual target, meaningful when res_taken=1
- res_ready  out  1  queue non-empty, so a resolve is accepted
- flush  out  1  one-cycle pulse: kill younger instructions and refetch
- redirect_pc  out  32  refetch address, valid while flush=1
- btb_valid  out  1  BTB write strobe, wired to the BTB valid_in
- btb_pc  out  32  BTB branch_PC
- btb_target  out  32  BTB branch_target
- stat_resolved  out  32  resolved-instruction count (STATS only)
- stat_mispredict  out  32  mispredict count (STATS only)

## Operation
- Queue is a circular FIFO of {pc, hit, target}.
  - Pointers are rd_ptr and wr_ptr, PTR_W bits, wrapping DEPTH-1 to 0.
  - count is PTR_W+1 bits.
- pred_ready = (count != DEPTH) & !flush.
  - It depends only on registered state, so a push into a full queue is refused even if a pop happens in the same cycle.
- res_ready = (count != 0).
  - A resolve is accepted when res_valid & res_ready.
  - res_valid with an empty queue is ignored.
- A push and a pop in the same cycle leave count unchanged.
- For the head entry E on an accepted resolve:
  - Taken and (!E.hit or E.target != res_target): mispredict, redirect to res_target, BTB write {E.pc, res_target}.
  - Not taken and E.hit: mispredict, redirect to E.pc+4 (32-bit wrap), no BTB write. The BTB has no invalidate.
  - Otherwise the prediction was correct: entry popped, no outputs.
- On a mispredict:
  - The queue is cleared at the same edge: count=0 and rd_ptr=wr_ptr.
  - A push offered in that cycle is dropped, since it is wrong-path.
- Pushes are refused while flush=1, because the instructions fetched that cycle are wrong-path too.

## Timing
- flush, redirect_pc, btb_valid, btb_pc and btb_target are registered.
  - A resolve accepted in cycle N produces them in cycle N+1 for exactly one cycle.
  - They return to 0 in cycle N+2 unless another event occurs.
- A BTB write issued in cycle N+1 is visible to a lookup in cycle N+2.
- The queue is empty from cycle N+1, so res_ready=0 in N+1.
- Reset values, asynchronous and immediate: queue empty, pointers 0, flush=0, redirect_pc=0, btb_valid=0, btb_pc=0, btb_target=0, stat_*=0, pred_ready=1, res_ready=0.
- Reset mid-operation: in-flight entries and a pending flush pulse are discarded, with no BTB write.

## Configuration
- BRU_STATS_EN defined:
  - stat_resolved increments on every accepted resolve.
  - stat_mispredict increments on every mispredict.
  - Both are 32-bit, wrap modulo 2^32 and hold through flush.
- BRU_STATS_EN undefined: the counters are not built and stat_resolved and stat_mispredict are tied to 0.

## Test plan
- Correct hit: push {0x100, hit=1, 0x200}, resolve taken 0x200 -> no flush, no btb_valid, queue empty.
- BTB miss on a jump: push {0x104, hit=0}, resolve taken 0x300 -> next cycle flush=1, redirect_pc=0x300, btb_valid=1, btb_pc=0x104, btb_target=0x300; a follow-up lookup at 0x104 hits.
- Wrong target: push {0x108, hit=1, 0x400}, resolve taken 0x500 -> flush, redirect_pc=0x500, BTB rewritten with target 0x500.
- False hit: push {0x10C, hit=1, 0x600}, resolve not taken -> flush, redirect_pc=0x110, btb_valid=0.
- Full, drop and reset:
  - DEPTH=8 pushes -> pred_ready=0; a ninth push is refused.
  - A mispredict on the head drops the 7 younger entries and a same-cycle push; count=0 afterwards.
  - Asserting rst mid-stream clears every output at once.
- With BRU_STATS_EN: after 10 resolves including 3 mispredicts -> stat_resolved=10, stat_mispredict=3. Without the macro, both read 0.
